ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard over the same key_clk/key_data pair that the scan-code receiver listens on. It sits beside the keyboard receiver in the game top level and drives the two lines open-collector through output enables. The receiver must ignore the bus while `tx_busy` is high.

---
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_host_tx.sv | 151 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/response handshake between the game logic and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, tx_start, input tx_busy, tx_done, tx_err);
  modport slave  (input tx_data, tx_start, output tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity out on device clock edges, then checks ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int SETUP_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 300000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx,
  input  logic          key_clk_in,
  input  logic          key_data_in,
  output logic          key_clk_oe,
  output logic          key_data_oe
);
  localparam int CMAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int TW   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, INHIBIT, SETUP, SEND, ACK, RECOVER, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tout_q, tout_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic [1:0]      ksc_q, ksc_d, ksd_q, ksd_d;
  logic            kc_prev_q, kc_prev_d;
  logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            fe;

  assign fe = ~ksc_q[1] & kc_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tout_d    = tout_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    ksc_d     = {ksc_q[0], key_clk_in};
    ksd_d     = {ksd_q[0], key_data_in};
    kc_prev_d = ksc_q[1];
    case (state_q)
      IDLE: if (tx.tx_start) begin
        byte_d    = tx.tx_data;
        cnt_d     = '0;
        busy_d    = 1'b1;
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        err_d     = 1'b0;
        state_d   = INHIBIT;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          tout_d   = '0;
          bit_d    = '0;
          state_d  = SEND;
        end
      end
      SEND, ACK, RECOVER: begin
        tout_d = tout_q + 1'b1;
        if (state_q == SEND && fe) begin
          // Line is open-collector: a 0 bit is driven, a 1 bit is released.
          if (bit_q < 4'd8)       data_oe_d = ~byte_q[bit_q[2:0]];
          else if (bit_q == 4'd8) data_oe_d = ^byte_q;
          else begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end
          if (bit_q != 4'hF) bit_d = bit_q + 1'b1;
        end
        if (state_q == ACK && fe) begin
          err_d   = ksd_q[1];
          state_d = RECOVER;
        end
        if (state_q == RECOVER && ksc_q[1] && ksd_q[1]) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
        // Timeout wins over any bus event in the same cycle.
        if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '1;
      tout_q    <= '1;
      bit_q     <= '1;
      byte_q    <= '1;
      ksc_q     <= '1;
      ksd_q     <= '1;
      kc_prev_q <= 1'b1;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      ksc_q     <= ksc_d;
      ksd_q     <= ksd_d;
      kc_prev_q <= kc_prev_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign key_clk_oe  = clk_oe_q;
  assign key_data_oe = data_oe_q;
  assign tx.tx_busy  = busy_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_err   = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a clocking PS/2 device model on open-collector lines,
// random bytes, expected frame bits/parity/timing computed from the protocol.
module tb_ps2_host_tx;
  localparam int INH = 200, SET = 16, TMO = 3000;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if txi();
  logic key_clk_oe, key_data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic kc_line, kd_line;
  assign kc_line = ~(key_clk_oe | dev_clk_low);
  assign kd_line = ~(key_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx(txi),
    .key_clk_in(kc_line), .key_data_in(kd_line),
    .key_clk_oe(key_clk_oe), .key_data_oe(key_data_oe));

  int checks = 0, errors = 0;
  int half = 40;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One device clock; data is sampled just before the rising edge.
  task automatic dclk(output logic s);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge clk);
    s = kd_line;
    dev_clk_low = 1'b0;
    repeat (half) @(negedge clk);
  endtask

  // mode: 0 ACK, 1 NACK, 2 stray start mid-frame, 3 reset after bit 3, 4 device silent
  task automatic frame(input logic [7:0] b, input int mode);
    logic [9:0] got;
    logic s, errv, exp_par;
    int n, dn;
    got = '0;
    exp_par = (($countones(b) % 2) == 0);
    @(negedge clk);
    txi.tx_data = b; txi.tx_start = 1'b1;
    @(negedge clk);
    txi.tx_start = 1'b0; txi.tx_data = 8'($urandom);
    chk("busy_rise", txi.tx_busy, 1);
    chk("clk_oe_rise", key_clk_oe, 1);
    n = 0;
    while (key_clk_oe && !key_data_oe && n < 5000) begin n++; @(negedge clk); end
    chk("inhibit_len", n, INH);
    n = 0;
    while (key_clk_oe && key_data_oe && n < 5000) begin n++; @(negedge clk); end
    chk("setup_len", n, SET);
    chk("start_bit", {kc_line, kd_line}, 2'b10);
    if (mode == 4) begin
      n = 0;
      while (!txi.tx_done && n < TMO + 100) begin @(negedge clk); n++; end
      chk("timeout_len", n, TMO);
      chk("timeout_err", txi.tx_err, 1);
      chk("timeout_oe", {key_clk_oe, key_data_oe}, 0);
      @(negedge clk);
      chk("timeout_busy_fall", {txi.tx_busy, txi.tx_done}, 0);
      return;
    end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (mode == 2 && k == 3) begin
        txi.tx_data = 8'h55; txi.tx_start = 1'b1;
        @(negedge clk);
        txi.tx_start = 1'b0;
      end
      dclk(s);
      got[k] = s;
      if (mode == 3 && k == 3) begin
        #2 rst = 1'b0;
        #1 chk("reset_oe", {key_clk_oe, key_data_oe}, 0);
        chk("reset_busy", txi.tx_busy, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (500) begin @(negedge clk); if (txi.tx_done) dn++; end
        chk("reset_no_done", dn, 0);
        return;
      end
    end
    chk("data_bits", got[7:0], b);
    chk("parity", got[8], exp_par);
    chk("stop", got[9], 1);
    // ACK clock: device pulls data low (or not) for the 11th clock.
    dev_data_low = (mode != 1);
    dev_clk_low = 1'b1;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    dn = 0; errv = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (txi.tx_done) begin dn++; errv = txi.tx_err; end
      @(negedge clk);
    end
    chk("done_count", dn, 1);
    chk("ack_err", errv, (mode == 1));
    chk("idle_oe", {key_clk_oe, key_data_oe}, 0);
    chk("idle_busy", txi.tx_busy, 0);
  endtask

  initial begin
    txi.tx_data = '0; txi.tx_start = 1'b0;
    #12;
    chk("rst_outputs", {key_clk_oe, key_data_oe, txi.tx_busy, txi.tx_done, txi.tx_err}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    half = 40;
    frame(8'hED, 0);
    frame(8'h00, 0);
    frame(8'hFF, 0);
    frame(8'h01, 0);
    frame(8'hF4, 0);
    frame(8'hED, 1);
    frame(8'hED, 4);
    frame(8'hED, 2);
    frame(8'($urandom), 3);
    frame(8'hF4, 0);
    for (int i = 0; i < 4; i++) begin
      half = int'($urandom_range(25, 60));
      frame(8'($urandom), int'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
